// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase/error encodings and dwell limits for the traffic
// light controller and its monitor.
package traffic_pkg;

    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    localparam logic [6:0] DWELL_MAIN   = 7'd70;
    localparam logic [6:0] DWELL_AMBER  = 7'd25;
    localparam logic [6:0] DWELL_ALLRED = 7'd1;
    localparam logic [6:0] DWELL_MAX    = 7'd127;

    typedef enum logic [2:0] {
        PH_HG  = 3'd0,
        PH_HY  = 3'd1,
        PH_AR1 = 3'd2,
        PH_LG  = 3'd3,
        PH_LY  = 3'd4,
        PH_AR2 = 3'd5
    } phase_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_ENC   = 3'd1,
        ERR_SEQ   = 3'd2,
        ERR_SHORT = 3'd3,
        ERR_LONG  = 3'd4,
        ERR_LATE  = 3'd5,
        ERR_SPUR  = 3'd6
    } err_t;

    typedef struct packed {
        logic   valid;
        phase_t ph;
    } lamp_dec_t;

    function automatic phase_t next_phase(phase_t p);
        case (p)
            PH_HG:   return PH_HY;
            PH_HY:   return PH_AR1;
            PH_AR1:  return PH_LG;
            PH_LG:   return PH_LY;
            PH_LY:   return PH_AR2;
            default: return PH_HG;
        endcase
    endfunction

    // All-red decodes to AR1; same_lamps() treats AR1 and AR2 as one lamp pair.
    function automatic lamp_dec_t decode_lamps(logic [2:0] hw, logic [2:0] lr);
        lamp_dec_t d;
        d.valid = 1'b1;
        case ({hw, lr})
            {LAMP_G, LAMP_R}: d.ph = PH_HG;
            {LAMP_Y, LAMP_R}: d.ph = PH_HY;
            {LAMP_R, LAMP_R}: d.ph = PH_AR1;
            {LAMP_R, LAMP_G}: d.ph = PH_LG;
            {LAMP_R, LAMP_Y}: d.ph = PH_LY;
            default: begin
                d.valid = 1'b0;
                d.ph    = PH_HG;
            end
        endcase
        return d;
    endfunction

    function automatic logic same_lamps(phase_t a, phase_t b);
        phase_t na;
        phase_t nb;
        na = (a == PH_AR2) ? PH_AR1 : a;
        nb = (b == PH_AR2) ? PH_AR1 : b;
        return na == nb;
    endfunction

    function automatic logic [6:0] req_dwell(phase_t p);
        case (p)
            PH_HG, PH_LG: return DWELL_MAIN;
            PH_HY, PH_LY: return DWELL_AMBER;
            default:      return DWELL_ALLRED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_dwell_cnt.sv
// Saturating dwell counter: load 1 on phase entry, count while the phase holds.
module dwell_cnt
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load_one,
    output logic [6:0] dwell
);

    // NOTE: clocked state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dwell <= '0;
        else if (load_one)
            dwell <= 7'd1;
        else if (inc && dwell != DWELL_MAX)
            dwell <= dwell + 7'd1;
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches the lamp outputs of the highway/local-road controller, tracks its
// phase and flags encoding, sequencing and timing violations.
module traffic_light_monitor
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hw_light,
    input  logic [2:0] lr_light,
    input  logic       lr_has_car,
    output logic [2:0] phase,
    output logic [6:0] dwell,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] viol_cnt,
    output logic [7:0] grant_cnt
);

    phase_t     phase_q, phase_d, nxt;
    err_t       err_code_q, err_now;
    lamp_dec_t  dec;
    logic [6:0] dwell_q;
    logic       err_q;
    logic [7:0] viol_q, grant_q;
    logic       inc, load_one, grant_inc;
    logic       late_arm_q, late_arm_d;
    logic       hg_car_q, hg_car_d;

    dwell_cnt u_dwell (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .load_one (load_one),
        .dwell    (dwell_q)
    );

    // late_arm: the last sample was HG at >= 70 edges with a car waiting.
    // hg_car: car sensor as seen in the most recent HG sample.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        dec        = decode_lamps(hw_light, lr_light);
        nxt        = next_phase(phase_q);
        phase_d    = phase_q;
        inc        = 1'b0;
        load_one   = 1'b0;
        err_now    = ERR_NONE;
        grant_inc  = 1'b0;
        late_arm_d = 1'b0;
        hg_car_d   = hg_car_q;

        if (!dec.valid) begin
            err_now = ERR_ENC;
        end else begin
            if (dec.ph == PH_HG)
                hg_car_d = lr_has_car;

            if (same_lamps(dec.ph, phase_q)) begin
                inc = 1'b1;
                if (phase_q == PH_HG) begin
                    if (late_arm_q)
                        err_now = ERR_LATE;
                    late_arm_d = lr_has_car && (dwell_q >= DWELL_MAIN - 7'd1);
                end else if (dwell_q == req_dwell(phase_q)) begin
                    err_now = ERR_LONG;
                end
            end else if (same_lamps(dec.ph, nxt)) begin
                load_one  = 1'b1;
                phase_d   = nxt;
                grant_inc = (phase_q == PH_LG);
                if (dwell_q < req_dwell(phase_q))
                    err_now = ERR_SHORT;
                else if (phase_q == PH_HG && !hg_car_q)
                    err_now = ERR_SPUR;
            end else begin
                load_one = 1'b1;
                phase_d  = dec.ph;
                err_now  = ERR_SEQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_HG;
            late_arm_q <= 1'b0;
            hg_car_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            viol_q     <= '0;
            grant_q    <= '0;
        end else begin
            phase_q    <= phase_d;
            late_arm_q <= late_arm_d;
            hg_car_q   <= hg_car_d;
            if (err_now != ERR_NONE) begin
                err_q <= 1'b1;
                if (viol_q != 8'hFF)
                    viol_q <= viol_q + 8'd1;
                if (err_code_q == ERR_NONE)
                    err_code_q <= err_now;
            end
            if (grant_inc)
                grant_q <= grant_q + 8'd1;
        end
    end

    assign phase     = phase_q;
    assign dwell     = dwell_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign viol_cnt  = viol_q;
    assign grant_cnt = grant_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: a behavioural model predicts every edge's outputs, a
// separate monitor compares them; directed scenarios add spot checks.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] hw_light = 3'b100;
    logic [2:0] lr_light = 3'b001;
    logic       lr_has_car = 1'b0;
    logic [2:0] phase;
    logic [6:0] dwell;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] viol_cnt;
    logic [7:0] grant_cnt;

    traffic_light_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .hw_light   (hw_light),
        .lr_light   (lr_light),
        .lr_has_car (lr_has_car),
        .phase      (phase),
        .dwell      (dwell),
        .err        (err),
        .err_code   (err_code),
        .viol_cnt   (viol_cnt),
        .grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int dw;
        int er;
        int code;
        int viol;
        int grant;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_no  = 0;

    // Phase table in order HG, HY, AR1, LG, LY, AR2.
    logic [2:0] hw_tab [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
    logic [2:0] lr_tab [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};
    int         req_tab[6] = '{70, 25, 1, 70, 25, 1};

    // Reference model state.
    int m_ph, m_dw, m_err, m_code, m_viol, m_grant;
    bit m_late, m_hg_car;

    function automatic int classify(logic [2:0] hw, logic [2:0] lr);
        for (int k = 0; k < 6; k++)
            if (hw == hw_tab[k] && lr == lr_tab[k]) return k;
        return -1;
    endfunction

    task automatic model_edge(input logic [2:0] hw, input logic [2:0] lr,
                              input logic car, input logic r);
        int   k, nx, code, new_dw;
        bit   same, to_next;
        exp_t e;
        if (r) begin
            m_ph = 0; m_dw = 0; m_err = 0; m_code = 0; m_viol = 0; m_grant = 0;
            m_late = 0; m_hg_car = 0;
        end else begin
            k = classify(hw, lr);
            code = 0;
            if (k < 0) begin
                code = 1;
                m_late = 0;
            end else begin
                nx      = (m_ph + 1) % 6;
                same    = (k == m_ph) || (k == 2 && m_ph == 5);
                to_next = (k == nx) || (k == 2 && nx == 5);
                if (same) begin
                    new_dw = (m_dw + 1 > 127) ? 127 : m_dw + 1;
                    if (m_ph == 0) begin
                        if (m_late) code = 5;
                        m_late = car && new_dw >= 70;
                    end else begin
                        m_late = 0;
                        if (new_dw == req_tab[m_ph] + 1) code = 4;
                    end
                    m_dw = new_dw;
                end else if (to_next) begin
                    m_late = 0;
                    if (m_dw < req_tab[m_ph]) code = 3;
                    else if (m_ph == 0 && !m_hg_car) code = 6;
                    if (m_ph == 3) m_grant = (m_grant + 1) % 256;
                    m_ph = nx;
                    m_dw = 1;
                end else begin
                    m_late = 0;
                    code = 2;
                    m_ph = k;
                    m_dw = 1;
                end
                if (k == 0) m_hg_car = car;
            end
            if (code != 0) begin
                m_err = 1;
                if (m_viol < 255) m_viol++;
                if (m_code == 0) m_code = code;
            end
        end
        e.ph = m_ph; e.dw = m_dw; e.er = m_err; e.code = m_code;
        e.viol = m_viol; e.grant = m_grant;
        exp_q.push_back(e);
    endtask

    // Monitor: one prediction per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                edge_no++;
                checks++;
                if (int'(phase) != e.ph || int'(dwell) != e.dw || int'(err) != e.er ||
                    int'(err_code) != e.code || int'(viol_cnt) != e.viol ||
                    int'(grant_cnt) != e.grant) begin
                    failures++;
                    $display("FAIL scoreboard edge %0d: got ph=%0d dw=%0d err=%0d code=%0d viol=%0d grant=%0d, expected ph=%0d dw=%0d err=%0d code=%0d viol=%0d grant=%0d",
                             edge_no, phase, dwell, err, err_code, viol_cnt, grant_cnt,
                             e.ph, e.dw, e.er, e.code, e.viol, e.grant);
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [2:0] hw, input logic [2:0] lr, input logic car);
        @(negedge clk);
        rst        = 1'b0;
        hw_light   = hw;
        lr_light   = lr;
        lr_has_car = car;
        model_edge(hw, lr, car, 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) begin
            @(negedge clk);
            rst = 1'b1;
            model_edge(hw_light, lr_light, lr_has_car, 1'b1);
        end
    endtask

    task automatic run(input int k, input int n, input logic car);
        repeat (n) drive(hw_tab[k], lr_tab[k], car);
    endtask

    task automatic legal_cycle(input logic car);
        run(0, 70, car); run(1, 25, car); run(2, 1, car);
        run(3, 70, car); run(4, 25, car); run(5, 1, car);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, r, nx;

        // Reset state
        do_reset();
        settle();
        check("reset_phase", phase, 0);
        check("reset_dwell", dwell, 0);
        check("reset_err", err, 0);
        check("reset_viol", viol_cnt, 0);

        // V1: controller-legal cycle
        legal_cycle(1'b1);
        run(0, 1, 1'b1);
        settle();
        check("v1_err", err, 0);
        check("v1_grant", grant_cnt, 1);
        check("v1_phase", phase, 0);

        // V2: short HG
        do_reset();
        run(0, 40, 1'b1);
        run(1, 1, 1'b1);
        settle();
        check("v2_code", err_code, 3);
        check("v2_viol", viol_cnt, 1);
        check("v2_phase", phase, 1);
        check("v2_dwell", dwell, 1);

        // V3: late grant, then no spurious flag on Y/R
        do_reset();
        run(0, 71, 1'b1);
        settle();
        check("v3_code", err_code, 5);
        run(1, 1, 1'b1);
        settle();
        check("v3_viol_no_spur", viol_cnt, 1);

        // V4: encoding errors during LG
        do_reset();
        run(0, 70, 1'b1); run(1, 25, 1'b1); run(2, 1, 1'b1); run(3, 10, 1'b1);
        drive(3'b100, 3'b100, 1'b1);
        settle();
        check("v4_code", err_code, 1);
        check("v4_phase", phase, 3);
        check("v4_dwell", dwell, 10);
        run(3, 60, 1'b1);
        drive(3'b000, 3'b001, 1'b0);
        settle();
        check("v4_viol", viol_cnt, 2);
        check("v4_code_kept", err_code, 1);
        check("v4_dwell_held", dwell, 70);

        // V5: long HY and long LG
        do_reset();
        run(0, 70, 1'b1); run(1, 26, 1'b1);
        settle();
        check("v5_code", err_code, 4);
        check("v5_viol_hy", viol_cnt, 1);
        run(2, 1, 1'b1); run(3, 71, 1'b1); run(4, 1, 1'b1);
        settle();
        check("v5_viol_lg", viol_cnt, 2);
        check("v5_grant", grant_cnt, 1);

        // Dwell saturation, spurious grant, out-of-order jump
        do_reset();
        run(0, 130, 1'b0);
        settle();
        check("sat_dwell", dwell, 127);
        check("sat_err", err, 0);
        run(1, 1, 1'b0);
        settle();
        check("spur_code", err_code, 6);
        run(3, 1, 1'b0);
        settle();
        check("seq_phase", phase, 3);
        check("seq_viol", viol_cnt, 2);

        // Randomized segments, mostly near-legal durations with injected faults
        do_reset();
        for (int s = 0; s < 80; s++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                nx  = (m_ph + 1) % 6;
                len = req_tab[nx] + int'($urandom_range(0, 2)) - 1;
                if (len < 1) len = 1;
                for (int n = 0; n < len; n++)
                    drive(hw_tab[nx], lr_tab[nx], $urandom_range(0, 3) != 0);
            end else if (r < 9) begin
                for (int n = 0; n < int'($urandom_range(1, 2)); n++)
                    drive(3'($urandom), 3'($urandom), 1'($urandom));
            end else begin
                run(int'($urandom_range(0, 5)), 1, 1'($urandom));
            end
        end

        // V6: reset mid-LY with an error pending, then grant counter wrap
        do_reset();
        run(0, 70, 1'b1); run(1, 25, 1'b1); run(2, 1, 1'b1);
        run(3, 70, 1'b1); run(4, 10, 1'b1);
        drive(3'b111, 3'b010, 1'b1);
        settle();
        check("v6_err_set", err, 1);
        do_reset();
        settle();
        check("v6_rst_phase", phase, 0);
        check("v6_rst_err", err, 0);
        check("v6_rst_code", err_code, 0);
        check("v6_rst_viol", viol_cnt, 0);
        check("v6_rst_dwell", dwell, 0);
        repeat (256) legal_cycle(1'b1);
        settle();
        check("v6_grant_wrap", grant_cnt, 0);
        check("v6_no_err", err, 0);

        repeat (2) settle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- hw_light  input  3  highway lamp, one-hot {G,Y,R} = 3'b100/010/001
- lr_light  input  3  local-road lamp, same encoding
- lr_has_car  input  1  local-road car sensor, as seen by the controller
- phase  output  3  tracked phase: 0 HG, 1 HY, 2 AR1, 3 LG, 4 LY, 5 AR2
- dwell  output  7  edges spent in the current phase, saturating at 127
- err  output  1  sticky error flag
- err_code  output  3  first error code (0 = none)
- viol_cnt  output  8  violation count, saturating at 255
- grant_cnt  output  8  completed LG phases, wraps at 255 -> 0

Function
REQ-002 Each rising clk edge SHALL sample hw_light, lr_light and lr_has_car (pre-edge values); all outputs are registered.
REQ-003 The legal lamp pairs SHALL be HG = G/R, HY = Y/R, AR1/AR2 = R/R, LG = R/G, LY = R/Y; any other pair is ENC (code 1).
REQ-004 The legal order SHALL be HG->HY->AR1->LG->LY->AR2->HG.
REQ-005 If the sampled pair equals the current phase, the block SHALL set dwell <= min(dwell+1,127).
REQ-006 If the sampled pair equals the next phase, the block SHALL check the departure dwell, then set phase <= next and dwell <= 1.
REQ-007 Required departure dwell SHALL be: HG >= 70; HY == 25; AR1 == 1; LG == 70; LY == 25; AR2 == 1.
REQ-008 A departure below the required dwell SHALL be SHORT (code 3).
REQ-009 Holding HY, LG or LY past its required dwell, or AR past 1, SHALL be LONG (code 4), flagged on the first excess edge only.
REQ-010 A legal pair that is neither the current phase nor the next SHALL be SEQ (code 2); the block SHALL then resync phase to that pair (R/R -> AR1) with dwell <= 1.
REQ-011 On an ENC sample the block SHALL hold phase and dwell.
REQ-012 If the HG sample had dwell >= 70 and lr_has_car = 1 and the next sample is still HG, the block SHALL flag LATE (code 5).
REQ-013 If HG->HY occurs while lr_has_car was 0 in the final HG sample, the block SHALL flag SPUR (code 6).
REQ-014 On the same edge, error priority SHALL be ENC > SEQ > SHORT > LONG > LATE > SPUR; one error per edge at most.
REQ-015 On any error the block SHALL set err <= 1 and increment viol_cnt (saturating), and SHALL load err_code only while it is 0.
REQ-016 On a legal LG->LY departure the block SHALL set grant_cnt <= grant_cnt + 1; a SHORT LG->LY departure still counts.

Reset
REQ-017 While rst is high the block SHALL hold phase = HG, dwell = 0, err = 0, err_code = 0, viol_cnt = 0, grant_cnt = 0; asserting rst mid-phase SHALL abort all checks immediately.
REQ-018 The first edge after rst deasserts SHALL be treated as a continuation of HG from dwell 0.

Structure
REQ-019 A shared package traffic_pkg SHALL hold the lamp codes, the phase enumeration, the dwell constants (70, 25, 1) and the error codes; the existing controller SHALL also use it.
REQ-020 The dwell counter (increment, load 1, hold, saturate) SHALL be the sub-module dwell_cnt; the phase/check logic stays in the top module.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- V1: drive the controller-legal cycle with car high; HG 70, HY 25, AR 1, LG 70, LY 25, AR 1, back to HG -> err = 0, grant_cnt = 1, phase returns to 0.
- V2: HG for 40 edges, then Y/R -> err_code = 3, viol_cnt = 1, phase = HY, dwell = 1.
- V3: HG 70 with car high, still G/R on edge 71 -> err_code = 5; then Y/R arrives -> no SPUR.
- V4: inject G/G for one edge during LG -> err_code = 1, phase and dwell unchanged; a subsequent ENC increments viol_cnt to 2 while err_code stays 1.
- V5: HY held for 26 edges -> err_code = 4 at edge 26 only; LG 71 edges -> viol_cnt increments once.
- V6: assert rst mid-LY with err = 1 -> all outputs zero and phase = HG; then 256 legal cycles -> grant_cnt wraps to 0.
